// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder constants and metric word types.
// Blocks take these as parameter defaults so they can be resized per instance.
package viterbi_pkg;
    localparam int DEF_WD_METR = 8;
    localparam int DEF_N_ACS   = 4;
    localparam int DEF_N_STATE = 64;
    localparam int DEF_W       = DEF_N_STATE / DEF_N_ACS;
    localparam int DEF_R       = DEF_W / 2;
    localparam int DEF_WAW     = $clog2(DEF_W);
    localparam int DEF_RAW     = $clog2(DEF_R);
    localparam int DEF_WD_WORD = DEF_WD_METR * DEF_N_ACS;

    typedef logic [DEF_WD_METR-1:0]                    metric_t;
    typedef logic [DEF_N_ACS-1:0][DEF_WD_METR-1:0]     wr_word_t;
    typedef logic [2*DEF_N_ACS-1:0][DEF_WD_METR-1:0]   rd_word_t;
endpackage

// File: rtl/metric_bank.sv
// One path-metric RAM bank: single write port, registered two-word read port.
// Word pair {2*addr+1, 2*addr} is returned one cycle after the read strobe.
module metric_bank
    import viterbi_pkg::*;
#(
    parameter int DW    = DEF_WD_WORD,
    parameter int DEPTH = DEF_W,
    parameter int AW    = DEF_WAW,
    parameter int RAW   = DEF_RAW
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_wr_en,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [DW-1:0]   i_wr_data,
    input  logic            i_rd_en,
    input  logic [RAW-1:0]  i_rd_addr,
    output logic [2*DW-1:0] o_rd_data
);
    logic [DW-1:0]   r_mem [DEPTH];
    logic [2*DW-1:0] r_rd_data;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        r_rd_data <= '0;
        else if (i_rd_en) r_rd_data <= {r_mem[{i_rd_addr, 1'b1}], r_mem[{i_rd_addr, 1'b0}]};
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/metric_pingpong_mem.sv
// Ping-pong path-metric store: ACS writes one bank while the next pass reads the other.
// Banks swap when every word of a pass is written; reads strip metric MSBs when the pass allows it.
module metric_pingpong_mem
    import viterbi_pkg::*;
#(
    parameter  int WD_METR = DEF_WD_METR,
    parameter  int N_ACS   = DEF_N_ACS,
    parameter  int N_STATE = DEF_N_STATE,
    localparam int W       = N_STATE / N_ACS,
    localparam int R       = W / 2,
    localparam int WAW     = $clog2(W),
    localparam int RAW     = $clog2(R),
    localparam int WD_WORD = WD_METR * N_ACS
) (
    input  logic                 i_Clock1,
    input  logic                 i_Reset,
    input  logic                 i_Active,
    input  logic                 i_WrValid,
    input  logic [WAW-1:0]       i_WrAddr,
    input  logic [WD_WORD-1:0]   i_WrData,
    input  logic                 i_RdEn,
    input  logic [RAW-1:0]       i_RdAddr,
    output logic [2*WD_WORD-1:0] o_RdData,
    output logic                 o_RdValid,
    output logic                 o_BankSel,
    output logic                 o_PassDone,
    output logic                 o_NormActive,
    output logic                 o_DupError
);
    logic [W-1:0]         r_bitmap;
    logic                 r_msb_acc;
    logic                 r_bank;
    logic                 r_norm;
    logic                 r_dup;
    logic                 r_pass_done;
    logic                 r_rd_valid;
    logic                 r_rd_bank;
    logic                 r_rd_norm;

    logic                 w_wr;
    logic                 w_rd;
    logic                 w_msb_all;
    logic                 w_complete;
    logic [W-1:0]         w_bitmap_set;
    logic [2*WD_WORD-1:0] w_bank_rd [2];
    logic [2*WD_WORD-1:0] w_rd_raw;
    logic [2*WD_WORD-1:0] w_msb_mask;

    assign w_wr         = i_WrValid & i_Active;
    assign w_rd         = i_RdEn & i_Active;
    assign w_bitmap_set = r_bitmap | (W'(1) << i_WrAddr);
    assign w_complete   = w_wr & (&w_bitmap_set);

    always_comb begin
        w_msb_all = 1'b1;
        for (int i = 0; i < N_ACS; i++) begin
            w_msb_all = w_msb_all & i_WrData[(i+1)*WD_METR-1];
        end
    end

    // The completing write itself contributes to NormActive, hence the w_msb_all term.
    always_ff @(posedge i_Clock1 or posedge i_Reset) begin
        if (i_Reset) begin
            r_bitmap    <= '0;
            r_msb_acc   <= 1'b1;
            r_bank      <= 1'b0;
            r_norm      <= 1'b0;
            r_dup       <= 1'b0;
            r_pass_done <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_rd_norm   <= 1'b0;
        end else begin
            r_pass_done <= w_complete;
            r_rd_valid  <= w_rd;
            if (w_complete) begin
                r_bank    <= ~r_bank;
                r_norm    <= r_msb_acc & w_msb_all;
                r_bitmap  <= '0;
                r_msb_acc <= 1'b1;
            end else if (w_wr) begin
                r_bitmap  <= w_bitmap_set;
                r_msb_acc <= r_msb_acc & w_msb_all;
            end
            if (w_wr && r_bitmap[i_WrAddr]) r_dup <= 1'b1;
            // Latch which bank/normalisation the in-flight read was issued against.
            if (w_rd) begin
                r_rd_bank <= ~r_bank;
                r_rd_norm <= r_norm;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        metric_bank #(
            .DW    (WD_WORD),
            .DEPTH (W),
            .AW    (WAW),
            .RAW   (RAW)
        ) u_bank (
            .i_clk     (i_Clock1),
            .i_rst     (i_Reset),
            .i_wr_en   (w_wr & (r_bank == 1'(b))),
            .i_wr_addr (i_WrAddr),
            .i_wr_data (i_WrData),
            .i_rd_en   (w_rd & (r_bank != 1'(b))),
            .i_rd_addr (i_RdAddr),
            .o_rd_data (w_bank_rd[b])
        );
    end

    for (genvar f = 0; f < 2*N_ACS; f++) begin : g_mask
        assign w_msb_mask[f*WD_METR +: WD_METR] = {1'b1, {(WD_METR-1){1'b0}}};
    end

    assign w_rd_raw     = r_rd_bank ? w_bank_rd[1] : w_bank_rd[0];
    assign o_RdData     = r_rd_norm ? (w_rd_raw & ~w_msb_mask) : w_rd_raw;
    assign o_RdValid    = r_rd_valid;
    assign o_BankSel    = r_bank;
    assign o_PassDone   = r_pass_done;
    assign o_NormActive = r_norm;
    assign o_DupError   = r_dup;
endmodule
